// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle for the scanned 7-segment snooper: display lines in, decoded digits/frames out.
// The master modport belongs to whoever drives the display lines; the decoder takes the slave side.
interface seg7_scan_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    digit_valid;
    logic [2:0]              digit_idx;
    logic [3:0]              digit_hex;
    logic                    digit_err;
    logic                    frame_valid;
    logic [4*NUM_DIGITS-1:0] frame_hex;
    logic                    frame_err;

    modport master (
        output seg,
        output an,
        input  digit_valid,
        input  digit_idx,
        input  digit_hex,
        input  digit_err,
        input  frame_valid,
        input  frame_hex,
        input  frame_err
    );

    modport slave (
        input  seg,
        input  an,
        output digit_valid,
        output digit_idx,
        output digit_hex,
        output digit_err,
        output frame_valid,
        output frame_hex,
        output frame_err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a time-multiplexed 7-segment bus: filters each dwell for
// stability, decodes the pattern and assembles complete NUM_DIGITS-wide frames.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_decoder_if.slave  bus
);
    localparam logic [7:0]            STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [6:0]              seg_prev_q;
    logic [NUM_DIGITS-1:0]   an_prev_q;
    logic [7:0]              cnt_q, cnt_d;
    logic                    same;

    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic                    frame_done;
    logic                    capture;

    logic                    an_onehot;
    logic [2:0]              onehot_idx;
    logic [3:0]              dec_hex;
    logic                    dec_err;

    logic [4*NUM_DIGITS-1:0] store_hex;
    logic [NUM_DIGITS-1:0]   store_err;

    logic                    digit_valid_q;
    logic [2:0]              digit_idx_q;
    logic [3:0]              digit_hex_q;
    logic                    digit_err_q;
    logic                    frame_valid_q;
    logic [4*NUM_DIGITS-1:0] frame_hex_q;
    logic                    frame_err_q;

    // Stability counter restarts at 1 on any change so the changed sample itself counts.
    assign same  = (bus.seg == seg_prev_q) && (bus.an == an_prev_q);
    assign cnt_d = !same ? 8'd1 : ((cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1);

    assign an_onehot = (bus.an != '0) && ((bus.an & (bus.an - AN_ONE)) == '0);

    always_comb begin
        onehot_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bus.an[k]) begin
                onehot_idx = onehot_idx | 3'(k);
            end
        end
    end

    always_comb begin
        dec_hex = 4'h0;
        dec_err = 1'b0;
        case (bus.seg)
            7'h3F: dec_hex = 4'h0;
            7'h06: dec_hex = 4'h1;
            7'h5B: dec_hex = 4'h2;
            7'h4F: dec_hex = 4'h3;
            7'h66: dec_hex = 4'h4;
            7'h6D: dec_hex = 4'h5;
            7'h7D: dec_hex = 4'h6;
            7'h07: dec_hex = 4'h7;
            7'h7F: dec_hex = 4'h8;
            7'h6F: dec_hex = 4'h9;
            7'h77: dec_hex = 4'hA;
            7'h7C: dec_hex = 4'hB;
            7'h39: dec_hex = 4'hC;
            7'h5E: dec_hex = 4'hD;
            7'h79: dec_hex = 4'hE;
            7'h71: dec_hex = 4'hF;
            default: dec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // LOCKED blocks repeat captures until the inputs move, however long the dwell lasts.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            HUNT: begin
                if ((cnt_d == STABLE_MAX) && an_onehot) begin
                    capture = 1'b1;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (!same) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // A full mask is flushed on the next edge; a capture on that same edge seeds the new frame.
    assign frame_done = &mask_q;

    always_comb begin
        mask_d = mask_q;
        if (frame_done) begin
            mask_d = '0;
        end
        if (capture) begin
            mask_d = mask_d | bus.an;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] hex_q;
            logic       err_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hex_q <= 4'h0;
                    err_q <= 1'b0;
                end else if (capture && bus.an[gi]) begin
                    hex_q <= dec_hex;
                    err_q <= dec_err;
                end
            end

            assign store_hex[4*gi +: 4] = hex_q;
            assign store_err[gi]        = err_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_prev_q    <= '0;
            an_prev_q     <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            digit_valid_q <= 1'b0;
            digit_idx_q   <= '0;
            digit_hex_q   <= '0;
            digit_err_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_hex_q   <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            seg_prev_q    <= bus.seg;
            an_prev_q     <= bus.an;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            digit_valid_q <= capture;
            frame_valid_q <= frame_done;
            if (capture) begin
                digit_idx_q <= onehot_idx;
                digit_hex_q <= dec_hex;
                digit_err_q <= dec_err;
            end
            if (frame_done) begin
                frame_hex_q <= store_hex;
                frame_err_q <= |store_err;
            end
        end
    end

    assign bus.digit_valid = digit_valid_q;
    assign bus.digit_idx   = digit_idx_q;
    assign bus.digit_hex   = digit_hex_q;
    assign bus.digit_err   = digit_err_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_hex   = frame_hex_q;
    assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: stimulus queues expected digits/frames with their
// arrival cycle, and a monitor thread pops and compares on every valid pulse.
module tb_seg7_scan_decoder;
    localparam int ND     = 4;
    localparam int STABLE = 4;

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic [3:0] hex;
        logic       err;
    } dexp_t;

    typedef struct {
        int          cyc;
        logic [15:0] hex;
        logic        err;
    } fexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    dexp_t dq[$];
    fexp_t fq[$];

    seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_decoder #(
        .NUM_DIGITS   (ND),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Entered on a negedge; inputs are sampled from the next posedge on.
    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n,
                         input bit cap, input logic [2:0] idx, input logic [3:0] hex, input bit err,
                         input bit fr, input logic [15:0] fhex, input bit ferr);
        dexp_t e;
        fexp_t f;
        if (cap) begin
            e.cyc = cyc + STABLE;
            e.idx = idx;
            e.hex = hex;
            e.err = err;
            dq.push_back(e);
        end
        if (fr) begin
            f.cyc = cyc + STABLE + 1;
            f.hex = fhex;
            f.err = ferr;
            fq.push_back(f);
        end
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        dwell(a, s, n, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic cap(input logic [3:0] a, input logic [6:0] s,
                       input logic [2:0] idx, input logic [3:0] hex, input bit err);
        dwell(a, s, 8, 1'b1, idx, hex, err, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic capf(input logic [3:0] a, input logic [6:0] s,
                        input logic [2:0] idx, input logic [3:0] hex, input bit err,
                        input logic [15:0] fhex, input bit ferr);
        dwell(a, s, 8, 1'b1, idx, hex, err, 1'b1, fhex, ferr);
    endtask

    task automatic check_zero(input string nm);
        logic [26:0] outs;
        outs = {bus.digit_valid, bus.digit_idx, bus.digit_hex, bus.digit_err,
                bus.frame_valid, bus.frame_hex, bus.frame_err};
        checks++;
        if (outs != '0) begin
            errors++;
            $display("FAIL %s: outputs=%h want 0", nm, outs);
        end else begin
            $display("ok   %s: all outputs 0", nm);
        end
    endtask

    task automatic monitor();
        dexp_t e;
        fexp_t f;
        forever begin
            @(negedge clk);
            if (bus.digit_valid) begin
                checks++;
                if (dq.size() == 0) begin
                    errors++;
                    $display("FAIL digit: unexpected pulse cyc=%0d idx=%0d hex=%h err=%b",
                             cyc, bus.digit_idx, bus.digit_hex, bus.digit_err);
                end else begin
                    e = dq.pop_front();
                    if (cyc != e.cyc || bus.digit_idx != e.idx || bus.digit_hex != e.hex ||
                        bus.digit_err != e.err) begin
                        errors++;
                        $display("FAIL digit: got cyc=%0d idx=%0d hex=%h err=%b, want cyc=%0d idx=%0d hex=%h err=%b",
                                 cyc, bus.digit_idx, bus.digit_hex, bus.digit_err,
                                 e.cyc, e.idx, e.hex, e.err);
                    end else begin
                        $display("ok   digit: cyc=%0d idx=%0d hex=%h err=%b",
                                 cyc, bus.digit_idx, bus.digit_hex, bus.digit_err);
                    end
                end
            end
            if (bus.frame_valid) begin
                checks++;
                if (fq.size() == 0) begin
                    errors++;
                    $display("FAIL frame: unexpected pulse cyc=%0d hex=%h err=%b",
                             cyc, bus.frame_hex, bus.frame_err);
                end else begin
                    f = fq.pop_front();
                    if (cyc != f.cyc || bus.frame_hex != f.hex || bus.frame_err != f.err) begin
                        errors++;
                        $display("FAIL frame: got cyc=%0d hex=%h err=%b, want cyc=%0d hex=%h err=%b",
                                 cyc, bus.frame_hex, bus.frame_err, f.cyc, f.hex, f.err);
                    end else begin
                        $display("ok   frame: cyc=%0d hex=%h err=%b", cyc, bus.frame_hex, bus.frame_err);
                    end
                end
            end
        end
    endtask

    initial begin
        bus.an  = '0;
        bus.seg = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after_release");

        // Basic scan 1,2,3,4
        cap (4'b0001, 7'h06, 3'd0, 4'h1, 1'b0);
        cap (4'b0010, 7'h5B, 3'd1, 4'h2, 1'b0);
        cap (4'b0100, 7'h4F, 3'd2, 4'h3, 1'b0);
        capf(4'b1000, 7'h66, 3'd3, 4'h4, 1'b0, 16'h4321, 1'b0);

        // Glitch filter: 3 samples of "0" must not be taken
        hold(4'b0001, 7'h3F, 3);
        dwell(4'b0001, 7'h7F, 10, 1'b1, 3'd0, 4'h8, 1'b0, 1'b0, 16'h0, 1'b0);

        // Invalid pattern, then completion with frame_err, then blank/multi-hot
        dwell(4'b0010, 7'h00, 6, 1'b1, 3'd1, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        cap (4'b0100, 7'h7D, 3'd2, 4'h6, 1'b0);
        capf(4'b1000, 7'h07, 3'd3, 4'h7, 1'b0, 16'h7608, 1'b1);
        hold(4'b0000, 7'h3F, 20);
        hold(4'b0011, 7'h06, 20);

        // Long dwell yields one capture; a seg change re-arms
        dwell(4'b0100, 7'h77, 50, 1'b1, 3'd2, 4'hA, 1'b0, 1'b0, 16'h0, 1'b0);
        dwell(4'b0100, 7'h7C, 10, 1'b1, 3'd2, 4'hB, 1'b0, 1'b0, 16'h0, 1'b0);

        // Overwrite of digit 0 before frame completion
        cap (4'b0001, 7'h6D, 3'd0, 4'h5, 1'b0);
        cap (4'b0010, 7'h7D, 3'd1, 4'h6, 1'b0);
        cap (4'b0001, 7'h6F, 3'd0, 4'h9, 1'b0);
        cap (4'b0100, 7'h39, 3'd2, 4'hC, 1'b0);
        capf(4'b1000, 7'h5E, 3'd3, 4'hD, 1'b0, 16'hDC69, 1'b0);

        // Reset mid-frame during digit 3's dwell
        cap (4'b0001, 7'h06, 3'd0, 4'h1, 1'b0);
        cap (4'b0010, 7'h5B, 3'd1, 4'h2, 1'b0);
        cap (4'b0100, 7'h4F, 3'd2, 4'h3, 1'b0);
        hold(4'b1000, 7'h79, 2);
        #1 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b0;

        // Descending scan: a stale mask would close the frame after the first capture
        cap (4'b1000, 7'h79, 3'd3, 4'hE, 1'b0);
        cap (4'b0100, 7'h79, 3'd2, 4'hE, 1'b0);
        cap (4'b0010, 7'h79, 3'd1, 4'hE, 1'b0);
        capf(4'b0001, 7'h79, 3'd0, 4'hE, 1'b0, 16'hEEEE, 1'b0);
        hold(4'b0000, 7'h00, 6);

        checks++;
        if (dq.size() != 0) begin
            errors++;
            $display("FAIL digit_queue: %0d expected digits never seen, want 0", dq.size());
        end
        checks++;
        if (fq.size() != 0) begin
            errors++;
            $display("FAIL frame_queue: %0d expected frames never seen, want 0", fq.size());
        end
        checks++;
        if (bus.frame_hex != 16'hEEEE || bus.frame_err != 1'b0) begin
            errors++;
            $display("FAIL frame_hold: got hex=%h err=%b, want hex=eeee err=0", bus.frame_hex, bus.frame_err);
        end
        checks++;
        if (bus.digit_idx != 3'd0 || bus.digit_hex != 4'hE || bus.digit_err != 1'b0) begin
            errors++;
            $display("FAIL digit_hold: got idx=%0d hex=%h err=%b, want idx=0 hex=e err=0",
                     bus.digit_idx, bus.digit_hex, bus.digit_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the team's hex-to-7-segment encoders.
- Snoops a time-multiplexed 7-segment bus (segment lines plus one-hot digit enables) and qualifies each digit dwell with a stability filter.
- Decodes each segment pattern back to a hex nibble and assembles a full N-digit frame.
- Used as a checker/monitor behind display drivers, and to recover values from scanned-display IP.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (width of `an`), 1..8.
- STABLE_CYCLES, 4: consecutive identical samples required before a dwell is accepted, 2..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seg  input  7  segment lines, active-high; seg[0]=a … seg[6]=g.
- an  input  NUM_DIGITS  digit enables, active-high; bit k selects digit k.
- digit_valid  output  1  one-cycle pulse: a dwell was accepted.
- digit_idx  output  3  index of the accepted digit; valid with digit_valid.
- digit_hex  output  4  decoded nibble; valid with digit_valid.
- digit_err  output  1  the accepted pattern is not in the table; valid with digit_valid.
- frame_valid  output  1  one-cycle pulse: every digit was captured since the last frame.
- frame_hex  output  4*NUM_DIGITS  digit k at [4k+3:4k]; held until the next frame.
- frame_err  output  1  at least one digit in the frame was invalid; held with frame_hex.

Behaviour:
- Reset: all outputs 0, state HUNT, capture mask 0, stability counter 0, sample registers 0.
- Sampling: (seg, an) registered every edge into prev. `same` = current inputs equal prev. `cnt` = 1 on mismatch, else cnt+1, saturating at STABLE_CYCLES.
- Decode table (seg hex → nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern: digit_hex=0, digit_err=1.
- FSM, two states:
  - HUNT → LOCKED when cnt reaches STABLE_CYCLES and `an` is exactly one-hot. That same edge registers digit_valid=1, digit_idx=onehot index, digit_hex/digit_err from the table, and sets mask bit and per-digit storage.
  - LOCKED → HUNT on any input change (same=0). No further capture within one dwell, however long.
  - an=0 (blanking) or multi-hot: never captured; the FSM stays in/returns to HUNT.
- Latency: inputs changed before edge E and held → digit_valid is high in the cycle after edge E+STABLE_CYCLES−1, and is exactly one cycle wide.
- Frame assembly:
  - When the capture sets the last missing mask bit: frame_valid pulses on the following edge; frame_hex/frame_err load all stored digits; mask clears.
  - Re-capture of an already-set digit before frame completion: overwrite its nibble/err bit; mask unchanged.
  - A capture coincident with mask clear starts the new frame (mask = that bit only).
- digit_idx, digit_hex, digit_err hold their last values between pulses. frame_hex and frame_err change only on frame_valid.
- Async rst mid-dwell: outputs clear immediately. After release, at least STABLE_CYCLES fresh samples are needed before any capture. A partial frame is discarded.
- NUM_DIGITS=1: every accepted digit produces a frame_valid one cycle after its digit_valid.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=4: scan an=0001/0010/0100/1000 with seg=06/5B/4F/66, 8 cycles each → four digit_valid pulses (idx 0..3, hex 1,2,3,4), then one frame_valid with frame_hex=16'h4321, frame_err=0.
- Glitch filter: an=0001, seg=3F held 3 cycles then seg=7F held 10 cycles → no capture of 0; single digit_valid, hex=8, at the 4th stable sample.
- Invalid/blank: seg=00 with an=0010 held 6 cycles → digit_valid, idx=1, hex=0, err=1; complete the frame → frame_err=1. an=0000 or an=0011 held 20 cycles → no digit_valid.
- Long dwell: an=0100, seg=77 held 50 cycles → exactly one digit_valid (hex=A); change to seg=7C → second digit_valid (hex=B) after 4 stable samples.
- Overwrite: capture digits 0,1 (values 5,6), re-capture digit 0 as 9, then capture 2,3 (C,D) → frame_hex=16'hDC69.
- Reset mid-frame: capture digits 0–2, assert rst for 2 cycles during digit 3's dwell → all outputs 0 immediately. A following full scan of E,E,E,E → frame_hex=16'hEEEE with no stale digits.
